// File: rtl/uart_bus_ctrl.sv
// CPU-side register front end for the UART core: CTRL/STAT/TXDATA/RXDATA, 16-deep TX/RX FIFOs,
// start-transmit sequencing and RXNE capture. Optional interrupt logic is built when UART_IRQ_EN is defined.
module uart_bus_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_uart_rstn,
  output logic        o_uart_en,
  output logic [3:0]  o_uart_br,
  output logic [7:0]  o_uart_clk_dec,
  output logic        o_uart_str_tx,
  output logic [7:0]  o_uart_data_tx,
  input  logic        i_uart_busy,
  input  logic        i_uart_rxne,
  input  logic [7:0]  i_uart_data_rx,
  output logic        o_irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAITB = 2'd1, ST_SEND = 2'd2, ST_GAP = 2'd3} tx_state_t;

  tx_state_t state_r, state_s;
  logic en_r, rxovf_r, rxne_q_r, str_tx_r;
  logic [3:0] br_r;
  logic [7:0] clk_dec_r, data_tx_r;
  logic [31:0] rdata_r, rd_mux_s, ctrl_rd_s, stat_s;
  logic [7:0] tx_mem_r [DEPTH];
  logic [7:0] rx_mem_r [DEPTH];
  logic [PW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r, tx_level_s, rx_level_s;
  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tbusy_s;
  logic wr_ctrl_s, wr_stat_s, wr_tx_s, rd_rx_s;
  logic tx_push_s, tx_pop_s, tx_flush_s, rx_capture_s, rx_push_s, rx_pop_s, rx_flush_s;

  assign wr_ctrl_s = i_we & (i_addr == 2'd0);
  assign wr_stat_s = i_we & (i_addr == 2'd1);
  assign wr_tx_s   = i_we & (i_addr == 2'd2);
  assign rd_rx_s   = i_re & (i_addr == 2'd3);

  // Full when the wrap bits differ but the index bits match
  assign tx_level_s = tx_wptr_r - tx_rptr_r;
  assign rx_level_s = rx_wptr_r - rx_rptr_r;
  assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
  assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
  assign tx_full_s  = (tx_wptr_r[FIFO_AW] != tx_rptr_r[FIFO_AW]) &&
                      (tx_wptr_r[FIFO_AW-1:0] == tx_rptr_r[FIFO_AW-1:0]);
  assign rx_full_s  = (rx_wptr_r[FIFO_AW] != rx_rptr_r[FIFO_AW]) &&
                      (rx_wptr_r[FIFO_AW-1:0] == rx_rptr_r[FIFO_AW-1:0]);

  assign tx_push_s    = wr_tx_s & ~tx_full_s;
  assign tx_flush_s   = wr_ctrl_s & i_wdata[2];
  assign rx_flush_s   = wr_ctrl_s & i_wdata[3];
  assign rx_capture_s = i_uart_rxne & ~rxne_q_r;
  assign rx_push_s    = rx_capture_s & ~rx_full_s;
  assign rx_pop_s     = rd_rx_s & ~rx_empty_s;
  assign tbusy_s      = ~tx_empty_s | (state_r != ST_IDLE) | i_uart_busy;

  // Control register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_r      <= 1'b0;
      br_r      <= 4'd0;
      clk_dec_r <= 8'd0;
    end else if (wr_ctrl_s) begin
      en_r      <= i_wdata[0];
      br_r      <= i_wdata[7:4];
      clk_dec_r <= i_wdata[15:8];
    end
  end

  // TX FIFO storage
  always_ff @(posedge i_clk) begin
    if (tx_push_s) tx_mem_r[tx_wptr_r[FIFO_AW-1:0]] <= i_wdata[7:0];
  end

  // TX FIFO pointers; a flush does not touch the byte already handed to the core
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wptr_r <= '0;
      tx_rptr_r <= '0;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
      if (tx_flush_s) tx_rptr_r <= tx_wptr_r;
      else if (tx_pop_s) tx_rptr_r <= tx_rptr_r + PTR_ONE;
    end
  end

  // RX FIFO storage
  always_ff @(posedge i_clk) begin
    if (rx_push_s) rx_mem_r[rx_wptr_r[FIFO_AW-1:0]] <= i_uart_data_rx;
  end

  // RX FIFO pointers, RXNE edge detect and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wptr_r <= '0;
      rx_rptr_r <= '0;
      rxne_q_r  <= 1'b0;
      rxovf_r   <= 1'b0;
    end else begin
      rxne_q_r <= i_uart_rxne;
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
      if (rx_flush_s) rx_rptr_r <= rx_wptr_r;
      else if (rx_pop_s) rx_rptr_r <= rx_rptr_r + PTR_ONE;
      if (rx_capture_s && rx_full_s) rxovf_r <= 1'b1;
      else if (wr_stat_s && i_wdata[3]) rxovf_r <= 1'b0;
    end
  end

  // TX sequencer next state; dropping EN abandons the in-flight byte
  always_comb begin
    state_s  = state_r;
    tx_pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_r && !tx_empty_s) begin
          tx_pop_s = 1'b1;
          state_s  = ST_WAITB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAITB: begin
        if (!en_r) state_s = ST_IDLE;
        else if (i_uart_busy) state_s = ST_SEND;
        else state_s = ST_WAITB;
      end
      ST_SEND: begin
        if (!en_r) state_s = ST_IDLE;
        else if (!i_uart_busy) state_s = ST_GAP;
        else state_s = ST_SEND;
      end
      ST_GAP:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // TX sequencer state and registered core handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      str_tx_r  <= 1'b0;
      data_tx_r <= 8'd0;
    end else begin
      state_r  <= state_s;
      str_tx_r <= (state_s == ST_WAITB) || (state_s == ST_SEND);
      if (tx_pop_s) data_tx_r <= tx_mem_r[tx_rptr_r[FIFO_AW-1:0]];
    end
  end

`ifdef UART_IRQ_EN
  logic rxie_r, txie_r, irq_r;
  logic unused_s;
  assign unused_s = &{1'b0, i_wdata[31:18], i_wdata[1]};

  // Interrupt enables
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rxie_r <= 1'b0;
      txie_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      rxie_r <= i_wdata[16];
      txie_r <= i_wdata[17];
    end
  end

  // Interrupt output, one cycle behind its sources
  always_ff @(posedge i_clk) begin
    if (i_rst) irq_r <= 1'b0;
    else irq_r <= (rxie_r & ~rx_empty_s) | (txie_r & tx_empty_s & (state_r == ST_IDLE)) | (rxie_r & rxovf_r);
  end
  assign o_irq = irq_r;
`else
  logic unused_s;
  assign unused_s = &{1'b0, i_wdata[31:16], i_wdata[1]};
  assign o_irq = 1'b0;
`endif

  // Readback images of CTRL and STAT
  always_comb begin
    ctrl_rd_s        = 32'd0;
    ctrl_rd_s[0]     = en_r;
    ctrl_rd_s[7:4]   = br_r;
    ctrl_rd_s[15:8]  = clk_dec_r;
`ifdef UART_IRQ_EN
    ctrl_rd_s[16]    = rxie_r;
    ctrl_rd_s[17]    = txie_r;
`endif
    stat_s           = 32'd0;
    stat_s[0]        = tbusy_s;
    stat_s[1]        = ~rx_empty_s;
    stat_s[2]        = tx_full_s;
    stat_s[3]        = rxovf_r;
    stat_s[8 +: PW]  = tx_level_s;
    stat_s[16 +: PW] = rx_level_s;
  end

  // Read data select
  always_comb begin
    rd_mux_s = 32'd0;
    case (i_addr)
      2'd0:    rd_mux_s = ctrl_rd_s;
      2'd1:    rd_mux_s = stat_s;
      2'd2:    rd_mux_s = 32'd0;
      2'd3:    rd_mux_s = rx_empty_s ? 32'd0 : {24'd0, rx_mem_r[rx_rptr_r[FIFO_AW-1:0]]};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data
  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_r <= 32'd0;
    else if (i_re) rdata_r <= rd_mux_s;
  end

  assign o_rdata        = rdata_r;
  assign o_uart_rstn    = ~i_rst;
  assign o_uart_en      = en_r;
  assign o_uart_br      = br_r;
  assign o_uart_clk_dec = clk_dec_r;
  assign o_uart_str_tx  = str_tx_r;
  assign o_uart_data_tx = data_tx_r;
endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
CPU-side controller for the UART peripheral core. It decodes a 4-register memory-mapped interface from the RV32I load/store unit and buffers TX and RX bytes in two FIFOs. It drives the core's start-transmit handshake (str_tx / busy_tx) and captures received bytes on the core's RXNE pulse. It sits between the CPU data bus and the UART core and owns that core's enable and configuration inputs.

Parameters:
FIFO_AW, 4, log2 of depth of each FIFO (depth 16); depth is always a power of two.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_addr  in  2  word select (CPU addr[3:2]): 0 CTRL, 1 STAT, 2 TXDATA, 3 RXDATA
i_we  in  1  write strobe, one cycle per access
i_re  in  1  read strobe, one cycle per access
i_wdata  in  32  write data
o_rdata  out  32  read data, registered, valid the cycle after i_re
o_uart_rstn  out  1  core reset, active-low, equals ~i_rst
o_uart_en  out  1  CTRL.EN
o_uart_br  out  4  CTRL.BR
o_uart_clk_dec  out  8  CTRL.CLK
o_uart_str_tx  out  1  start-transmit request to core
o_uart_data_tx  out  8  byte to core; held stable while str_tx is high
i_uart_busy  in  1  core busy_tx
i_uart_rxne  in  1  core RXNE (high 1-2 cycles per byte)
i_uart_data_rx  in  8  core received byte
o_irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset: CTRL=0, both FIFOs empty, RXOVF=0, o_rdata=0, o_uart_str_tx=0, o_uart_data_tx=0, o_irq=0, TX FSM in IDLE, rxne edge register=0.
- CTRL (RW): B0 EN, B7:4 BR, B15:8 CLK. B2 TXFLUSH and B3 RXFLUSH are self-clearing: writing 1 empties that FIFO in the same cycle, and they read as 0. All other bits read 0.
- STAT (RO except B3): B0 TBUSY = TX FIFO non-empty OR FSM not IDLE OR i_uart_busy. B1 RXNE = RX FIFO non-empty. B2 TXFULL. B3 RXOVF is sticky; writing 1 clears it. B[12:8] TX level (0..16). B[20:16] RX level.
- TXDATA write: pushes wdata[7:0]. If the FIFO is full the byte is dropped and no state changes. Reads return 0.
- RXDATA read: o_rdata[7:0] = head byte and pops it. If empty, returns 0 and does not pop. Writes are ignored.
- RX capture: push i_uart_data_rx on the rising edge of i_uart_rxne (registered edge detect), exactly one push per byte. If the FIFO is full, drop the byte and set RXOVF. A simultaneous CPU pop and capture push are both honoured; the level is unchanged.
- TX FSM:
  - IDLE: when EN=1 and FIFO non-empty, pop the head into o_uart_data_tx, set str_tx=1, go to WAITB.
  - WAITB: when i_uart_busy=1, go to SEND.
  - SEND: when i_uart_busy=0 (core finished its stop bit), set str_tx=0 and go to GAP.
  - GAP: one cycle with str_tx=0 so the core can leave its DONE state, then go to IDLE.
  - Minimum spacing between consecutive str_tx assertions is 2 cycles.
- EN deasserted mid-byte: the FSM returns to IDLE next cycle with str_tx=0. The in-flight byte is lost. FIFO contents are kept.
- TXFLUSH mid-byte does not abort the current byte.
- Simultaneous CPU push and FSM pop on the same FIFO are both honoured.
- FIFO pointers are FIFO_AW+1 bits with wrap; full/empty are derived from the MSB compare.

Optional Feature:
UART_IRQ_EN
- Defined: CTRL B16 RXIE and B17 TXIE are RW.
- o_irq = (RXIE & RXNE) | (TXIE & TX FIFO empty & FSM IDLE) | (RXIE & RXOVF), registered with 1-cycle latency.
- Undefined: o_irq is tied 0, and B17:16 read 0 and ignore writes.

Test Plan:
1. Reset, then read STAT -> o_rdata=0x00000000. Read CTRL -> 0.
2. Write CTRL=0xFF41 (EN, BR=4), write TXDATA 0x55 then 0xA3, with a behavioural core model -> str_tx rises twice with data_tx 0x55 then 0xA3, str_tx low for at least 1 cycle between them, and TBUSY reads 0 after the second stop bit.
3. Write 17 bytes with EN=0 -> TX level=16, TXFULL=1, 17th byte dropped. Set EN -> exactly 16 bytes are sent, in order.
4. Pulse rxne high for 2 cycles with data 0x31 -> RX level=1. Read RXDATA -> 0x31. Read again -> 0, level 0.
5. Inject 17 RX bytes with no reads -> RXOVF=1, level 16, first 16 bytes intact. Write STAT with B3=1 -> RXOVF=0.
6. Drop EN while in SEND -> str_tx=0 next cycle, FSM IDLE, remaining FIFO bytes retained. With UART_IRQ_EN and RXIE=1, one received byte -> o_irq=1 until the RX FIFO is drained.
